// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_IF) ? OWN_D : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the port arbiter; master = arbiter, slave = core/memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              timeout_err;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output timeout_err
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  timeout_err
    );

endinterface

// File: rtl/arb_pick2.sv
// Combinational two-way pick between fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise data always wins ties.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic   req_if,
    input  logic   req_d,
    input  owner_t last,
    output logic   valid,
    output owner_t pick
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = (last == OWN_D);
`endif

    always_comb begin
        valid = req_if | req_d;
        pick  = OWN_IF;
        if (req_d && !req_if) begin
            pick = OWN_D;
        end else if (req_d && req_if) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick = other_owner(last);
`else
            pick = OWN_D;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters, one access in flight.
// Tie-break policy is set by ARB_ROUND_ROBIN_EN (see arb_pick2); TIMEOUT=0 disables the hang watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int unsigned CNT_W   = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

    state_t            state, state_next;
    owner_t            owner, last_winner, pick;
    logic              pick_valid;
    logic              take, accept, resp_fire, abort, to_hit;
    logic [DATA_W-1:0] resp_data;
    logic [CNT_W-1:0]  to_cnt;

    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              if_rvalid, d_rvalid, timeout_err;
    logic [DATA_W-1:0] if_rdata, d_rdata;

    arb_pick2 u_pick (
        .req_if (bus.if_req),
        .req_d  (bus.d_req),
        .last   (last_winner),
        .valid  (pick_valid),
        .pick   (pick)
    );

    // Counter saturates, so a late accept in the last ISSUE cycle still ends in a timeout.
    assign to_hit = (TIMEOUT != 0) && (to_cnt >= CNT_W'(TO_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        accept     = 1'b0;
        resp_fire  = 1'b0;
        abort      = 1'b0;
        resp_data  = '0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    take       = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ready) begin
                    accept = 1'b1;
                    if (mem_we) begin
                        resp_fire  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else if (to_hit) begin
                    abort      = 1'b1;
                    resp_fire  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    resp_fire  = 1'b1;
                    resp_data  = bus.mem_rdata;
                    state_next = ST_IDLE;
                end else if (to_hit) begin
                    abort      = 1'b1;
                    resp_fire  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, response routing and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner       <= OWN_IF;
            last_winner <= OWN_IF;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            to_cnt      <= '0;
            if_rvalid   <= 1'b0;
            if_rdata    <= '0;
            d_rvalid    <= 1'b0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (take) begin
                owner       <= pick;
                last_winner <= pick;
                mem_req     <= 1'b1;
                to_cnt      <= '0;
                if (pick == OWN_D) begin
                    mem_we    <= bus.d_we;
                    mem_addr  <= bus.d_addr;
                    mem_wdata <= bus.d_wdata;
                    mem_be    <= bus.d_be;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= bus.if_addr;
                    mem_wdata <= '0;
                    mem_be    <= '0;
                end
            end else if (state != ST_IDLE && to_cnt < CNT_W'(TO_LAST)) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
            if (accept || abort) begin
                mem_req <= 1'b0;
            end
            if (resp_fire) begin
                if (owner == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= resp_data;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= resp_data;
                end
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign bus.if_gnt      = (state == ST_ISSUE) && bus.mem_ready && (owner == OWN_IF);
    assign bus.d_gnt       = (state == ST_ISSUE) && bus.mem_ready && (owner == OWN_D);
    assign bus.if_rvalid   = if_rvalid;
    assign bus.if_rdata    = if_rdata;
    assign bus.d_rvalid    = d_rvalid;
    assign bus.d_rdata     = d_rdata;
    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.mem_be      = mem_be;
    assign bus.timeout_err = timeout_err;

endmodule
